// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and control-bundle types for the RV32I
// 3-stage pipeline controller (IF/D, EX, MEM/WB).
//   opcode_e     : instruction opcode keyed on inst[6:2]
//   ALU_* / WB_* / SSEL_* / LD_* : ALUSel, WBSel, SSel and LdSel codes
//   ctrl_t       : decoded control bundle carried from IF/D into EX
//   wb_t         : slice of the bundle still needed in WB
//   CTRL_BUBBLE / WB_BUBBLE : bundle values for a bubble
package ctrl_pkg;

    typedef enum logic [4:0] {
        OP_LOAD   = 5'd0,
        OP_IMM    = 5'd4,
        OP_AUIPC  = 5'd5,
        OP_STORE  = 5'd8,
        OP_REG    = 5'd12,
        OP_LUI    = 5'd13,
        OP_BRANCH = 5'd24,
        OP_JALR   = 5'd25,
        OP_JAL    = 5'd27
    } opcode_e;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_PASS_B = 4'd15;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] SSEL_NONE = 2'd3;
    localparam logic [2:0] LD_WORD   = 3'd2;

    typedef struct packed {
        logic [3:0] alu_sel;
        logic       a_sel;
        logic       b_sel;
        logic       mem_rw;
        logic [1:0] s_sel;
        logic       br_un;
        logic       is_branch;
        logic       is_jump;
        logic [2:0] funct3;
        logic [1:0] wb_sel;
        logic       reg_wr_en;
        logic [2:0] ld_sel;
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrl_t;

    typedef struct packed {
        logic [1:0] wb_sel;
        logic       reg_wr_en;
        logic [2:0] ld_sel;
        logic [4:0] rd;
    } wb_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        alu_sel:   ALU_ADD,
        a_sel:     1'b0,
        b_sel:     1'b0,
        mem_rw:    1'b0,
        s_sel:     SSEL_NONE,
        br_un:     1'b0,
        is_branch: 1'b0,
        is_jump:   1'b0,
        funct3:    3'd0,
        wb_sel:    WB_MEM,
        reg_wr_en: 1'b0,
        ld_sel:    LD_WORD,
        use_rs1:   1'b0,
        use_rs2:   1'b0,
        rs1:       5'd0,
        rs2:       5'd0,
        rd:        5'd0
    };

    localparam wb_t WB_BUBBLE = '{
        wb_sel:    WB_MEM,
        reg_wr_en: 1'b0,
        ld_sel:    LD_WORD,
        rd:        5'd0
    };

    // funct3[2] picks less-than vs equal; funct3[0] inverts (bne/bge/bgeu).
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic br_eq,
                                          input logic br_lt);
        return (funct3[2] ? br_lt : br_eq) ^ funct3[0];
    endfunction

endpackage

// File: rtl/controller_decode.sv
// controller_decode: purely combinational RV32I instruction decoder.
//   inst : 32-bit instruction at IF/D
//   ctrl : decoded control bundle (bubble for unsupported opcodes)
// Register-read flags are set only for formats that really read rs1/rs2,
// so immediate bits sitting in the rs fields never look like operands.
module controller_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl
);

    logic [2:0] funct3;
    logic       f7b5;
    logic       unused_bits;

    assign funct3      = inst[14:12];
    assign f7b5        = inst[30];
    assign unused_bits = ^{inst[31], inst[29:25], inst[1:0]};

    always_comb begin
        ctrl        = CTRL_BUBBLE;
        ctrl.rd     = inst[11:7];
        ctrl.rs1    = inst[19:15];
        ctrl.rs2    = inst[24:20];
        ctrl.funct3 = funct3;
        case (inst[6:2])
            OP_REG: begin
                ctrl.alu_sel   = {f7b5, funct3};
                ctrl.wb_sel    = WB_ALU;
                ctrl.reg_wr_en = 1'b1;
                ctrl.use_rs1   = 1'b1;
                ctrl.use_rs2   = 1'b1;
            end
            OP_IMM: begin
                // Only the shift-right pair uses funct7[5] (srli/srai).
                ctrl.alu_sel   = {(funct3 == 3'd5) & f7b5, funct3};
                ctrl.b_sel     = 1'b1;
                ctrl.wb_sel    = WB_ALU;
                ctrl.reg_wr_en = 1'b1;
                ctrl.use_rs1   = 1'b1;
            end
            OP_LOAD: begin
                ctrl.b_sel     = 1'b1;
                ctrl.mem_rw    = 1'b1;
                ctrl.wb_sel    = WB_MEM;
                ctrl.reg_wr_en = 1'b1;
                ctrl.ld_sel    = funct3;
                ctrl.use_rs1   = 1'b1;
            end
            OP_STORE: begin
                ctrl.b_sel   = 1'b1;
                ctrl.mem_rw  = 1'b1;
                ctrl.s_sel   = funct3[1:0];
                ctrl.use_rs1 = 1'b1;
                ctrl.use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.a_sel     = 1'b1;
                ctrl.b_sel     = 1'b1;
                ctrl.br_un     = funct3[1];
                ctrl.is_branch = 1'b1;
                ctrl.use_rs1   = 1'b1;
                ctrl.use_rs2   = 1'b1;
            end
            OP_JAL: begin
                ctrl.a_sel     = 1'b1;
                ctrl.b_sel     = 1'b1;
                ctrl.is_jump   = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                ctrl.reg_wr_en = 1'b1;
            end
            OP_JALR: begin
                ctrl.b_sel     = 1'b1;
                ctrl.is_jump   = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                ctrl.reg_wr_en = 1'b1;
                ctrl.use_rs1   = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_sel   = ALU_PASS_B;
                ctrl.b_sel     = 1'b1;
                ctrl.wb_sel    = WB_ALU;
                ctrl.reg_wr_en = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.a_sel     = 1'b1;
                ctrl.b_sel     = 1'b1;
                ctrl.wb_sel    = WB_ALU;
                ctrl.reg_wr_en = 1'b1;
            end
            default: ctrl = CTRL_BUBBLE;
        endcase
    end

endmodule

// File: rtl/controller.sv
// controller: control unit for the 3-stage RV32I pipeline (IF/D, EX, MEM/WB).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   inst                : instruction in IF/D
//   BrEq, BrLt          : comparator flags for the EX instruction
//   FA_1, FB_1          : IF/D register-read bypass from WB
//   FA_2, FB_2          : EX operand bypass from WB
//   PCSel, InstSel      : next-PC select, IF/D NOP insertion
//   BrUn, ASel, BSel, ALUSel, MemRW, SSel : EX controls
//   WBSel, RegWrEn, LdSel                 : WB controls
// Build option: define CTRL_FORWARD_EN to enable forwarding selects;
// otherwise FA_1/FB_1/FA_2/FB_2 are tied low.
module controller
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        BrEq,
    input  logic        BrLt,
    output logic        FA_1,
    output logic        FB_1,
    output logic        FA_2,
    output logic        FB_2,
    output logic        PCSel,
    output logic        InstSel,
    output logic        BrUn,
    output logic        ASel,
    output logic        BSel,
    output logic [3:0]  ALUSel,
    output logic        MemRW,
    output logic [1:0]  SSel,
    output logic [1:0]  WBSel,
    output logic        RegWrEn,
    output logic [2:0]  LdSel
);

    ctrl_t dec_ctrl;
    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    wb_t   wb_ctrl;
    logic  started;

    controller_decode u_decode (
        .inst (inst),
        .ctrl (dec_ctrl)
    );

    // Instruction memory output is not valid until one edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) started <= 1'b0;
        else      started <= 1'b1;
    end

    assign InstSel = ~started;

    always_comb begin
        id_ctrl = dec_ctrl;
        if (InstSel) id_ctrl = CTRL_BUBBLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_ctrl <= CTRL_BUBBLE;
            wb_ctrl <= WB_BUBBLE;
        end else begin
            ex_ctrl           <= id_ctrl;
            wb_ctrl.wb_sel    <= ex_ctrl.wb_sel;
            wb_ctrl.reg_wr_en <= ex_ctrl.reg_wr_en;
            wb_ctrl.ld_sel    <= ex_ctrl.ld_sel;
            wb_ctrl.rd        <= ex_ctrl.rd;
        end
    end

    assign BrUn    = ex_ctrl.br_un;
    assign ASel    = ex_ctrl.a_sel;
    assign BSel    = ex_ctrl.b_sel;
    assign ALUSel  = ex_ctrl.alu_sel;
    assign MemRW   = ex_ctrl.mem_rw;
    assign SSel    = ex_ctrl.s_sel;
    assign PCSel   = ex_ctrl.is_jump |
                     (ex_ctrl.is_branch & branch_taken(ex_ctrl.funct3, BrEq, BrLt));

    assign WBSel   = wb_ctrl.wb_sel;
    assign RegWrEn = wb_ctrl.reg_wr_en;
    assign LdSel   = wb_ctrl.ld_sel;

`ifdef CTRL_FORWARD_EN
    logic wb_writes;
    assign wb_writes = wb_ctrl.reg_wr_en & (wb_ctrl.rd != 5'd0);
    assign FA_1 = wb_writes & id_ctrl.use_rs1 & (id_ctrl.rs1 == wb_ctrl.rd);
    assign FB_1 = wb_writes & id_ctrl.use_rs2 & (id_ctrl.rs2 == wb_ctrl.rd);
    assign FA_2 = wb_writes & ex_ctrl.use_rs1 & (ex_ctrl.rs1 == wb_ctrl.rd);
    assign FB_2 = wb_writes & ex_ctrl.use_rs2 & (ex_ctrl.rs2 == wb_ctrl.rd);
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_ctrl.use_rs1, ex_ctrl.use_rs2, ex_ctrl.rs1,
                          ex_ctrl.rs2, wb_ctrl.rd};
    assign FA_1 = 1'b0;
    assign FB_1 = 1'b0;
    assign FA_2 = 1'b0;
    assign FB_2 = 1'b0;
`endif

endmodule

// File: tb/tb_controller.sv
// tb_controller: directed-vector bench for the pipeline controller.
// A behavioural model tracks which instruction sits in each stage and
// derives expected controls from the instruction encoding; a compare
// process checks every output on each falling edge, and literal checks
// pin selected expectations at hand-computed points.
module tb_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst = 32'hFFFF_FFFF;
    logic        BrEq = 1'b0;
    logic        BrLt = 1'b0;
    logic        FA_1, FB_1, FA_2, FB_2, PCSel, InstSel, BrUn, ASel, BSel;
    logic [3:0]  ALUSel;
    logic        MemRW;
    logic [1:0]  SSel;
    logic [1:0]  WBSel;
    logic        RegWrEn;
    logic [2:0]  LdSel;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BUB   = 32'hFFFF_FFFF; // opcode 31: not decoded
    localparam logic [31:0] LW    = 32'h0001a103;  // lw   x2,0(x3)
    localparam logic [31:0] SH    = 32'h00219023;  // sh   x2,0(x3)
    localparam logic [31:0] SUB   = 32'h401201b3;  // sub  x3,x4,x1
    localparam logic [31:0] SRAI  = 32'h40425193;  // srai x3,x4,4
    localparam logic [31:0] LUI   = 32'h003e8137;  // lui  x2,0x3e8
    localparam logic [31:0] BGEU  = 32'h060f7463;
    localparam logic [31:0] BEQ   = 32'h060f0e63;
    localparam logic [31:0] JALR  = 32'h06438067;  // jalr x0,100(x7)
    localparam logic [31:0] ADD1  = 32'h001201b3;  // add  x3,x4,x1
    localparam logic [31:0] ADD2  = 32'h003182b3;  // add  x5,x3,x3

    controller dut (
        .clk(clk), .rst(rst), .inst(inst), .BrEq(BrEq), .BrLt(BrLt),
        .FA_1(FA_1), .FB_1(FB_1), .FA_2(FA_2), .FB_2(FB_2),
        .PCSel(PCSel), .InstSel(InstSel), .BrUn(BrUn), .ASel(ASel),
        .BSel(BSel), .ALUSel(ALUSel), .MemRW(MemRW), .SSel(SSel),
        .WBSel(WBSel), .RegWrEn(RegWrEn), .LdSel(LdSel)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit valid, a, b, mem, brun, wr, r1, r2, branch, jump;
        int alu, ssel, wbsel, ldsel, f3, rd, rs1, rs2;
    } exp_t;

    function automatic exp_t model(input logic [31:0] i);
        exp_t m;
        int op;
        op = int'(i[6:2]);
        m = '{default: 0};
        m.ssel = 3; m.ldsel = 2;
        m.f3 = int'(i[14:12]); m.rd = int'(i[11:7]);
        m.rs1 = int'(i[19:15]); m.rs2 = int'(i[24:20]);
        if (op == 12) begin       // R-type
            m.valid = 1; m.alu = (i[30] ? 8 : 0) + m.f3;
            m.wbsel = 1; m.wr = 1; m.r1 = 1; m.r2 = 1;
        end else if (op == 4) begin   // I-type ALU
            m.valid = 1; m.alu = ((m.f3 == 5 && i[30]) ? 8 : 0) + m.f3;
            m.b = 1; m.wbsel = 1; m.wr = 1; m.r1 = 1;
        end else if (op == 0) begin   // load
            m.valid = 1; m.b = 1; m.mem = 1; m.wbsel = 0; m.wr = 1;
            m.ldsel = m.f3; m.r1 = 1;
        end else if (op == 8) begin   // store
            m.valid = 1; m.b = 1; m.mem = 1; m.ssel = m.f3 % 4; m.r1 = 1; m.r2 = 1;
        end else if (op == 24) begin  // branch
            m.valid = 1; m.a = 1; m.b = 1; m.brun = (m.f3 >= 6); m.branch = 1;
            m.r1 = 1; m.r2 = 1;
        end else if (op == 27) begin  // jal
            m.valid = 1; m.a = 1; m.b = 1; m.jump = 1; m.wbsel = 2; m.wr = 1;
        end else if (op == 25) begin  // jalr
            m.valid = 1; m.b = 1; m.jump = 1; m.wbsel = 2; m.wr = 1; m.r1 = 1;
        end else if (op == 13) begin  // lui
            m.valid = 1; m.alu = 15; m.b = 1; m.wbsel = 1; m.wr = 1;
        end else if (op == 5) begin   // auipc
            m.valid = 1; m.a = 1; m.b = 1; m.wbsel = 1; m.wr = 1;
        end
        if (!m.valid) m.rd = 0;
        return m;
    endfunction

    function automatic bit taken(input int f3, input bit eq, input bit lt);
        case (f3)
            0:       return eq;
            1:       return !eq;
            4, 6:    return lt;
            5, 7:    return !lt;
            default: return 0;
        endcase
    endfunction

    function automatic bit fwd(input bit reads, input int src, input exp_t wb);
`ifdef CTRL_FORWARD_EN
        return reads && wb.wr && wb.rd != 0 && wb.rd == src;
`else
        return 0;
`endif
    endfunction

    logic [31:0] m_ex = BUB;
    logic [31:0] m_wb = BUB;
    bit          m_started = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ex <= BUB; m_wb <= BUB; m_started <= 0;
        end else begin
            m_wb <= m_ex;
            m_ex <= m_started ? inst : BUB;
            m_started <= 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        exp_t ex, wb, id;
        ex = model(m_ex);
        wb = model(m_wb);
        id = model(m_started ? inst : BUB);
        chk("InstSel", int'(InstSel), int'(!m_started));
        chk("ASel",    int'(ASel),    int'(ex.a));
        chk("BSel",    int'(BSel),    int'(ex.b));
        chk("ALUSel",  int'(ALUSel),  ex.alu);
        chk("MemRW",   int'(MemRW),   int'(ex.mem));
        chk("SSel",    int'(SSel),    ex.ssel);
        chk("BrUn",    int'(BrUn),    int'(ex.brun));
        chk("PCSel",   int'(PCSel),
            int'(ex.jump || (ex.branch && taken(ex.f3, BrEq, BrLt))));
        chk("WBSel",   int'(WBSel),   wb.wbsel);
        chk("RegWrEn", int'(RegWrEn), int'(wb.wr));
        if (wb.valid) chk("LdSel", int'(LdSel), wb.ldsel);
        chk("FA_1", int'(FA_1), int'(fwd(id.r1, id.rs1, wb)));
        chk("FB_1", int'(FB_1), int'(fwd(id.r2, id.rs2, wb)));
        chk("FA_2", int'(FA_2), int'(fwd(ex.r1, ex.rs1, wb)));
        chk("FB_2", int'(FB_2), int'(fwd(ex.r2, ex.rs2, wb)));
    end

    // ---------------- directed stimulus ----------------
    // At each rising edge the previous inst moves to EX; eq/lt are its flags.
    task automatic drive(input logic [31:0] i, input logic eq, input logic lt);
        @(posedge clk); #1;
        inst = i; BrEq = eq; BrLt = lt;
    endtask

    localparam bit FWD_ON =
`ifdef CTRL_FORWARD_EN
        1'b1;
`else
        1'b0;
`endif

    logic [31:0] prog [16] = '{LW, SH, SUB, SRAI, LUI, BGEU, BEQ, JALR,
                               ADD1, ADD2, 32'h00328293, 32'h0052a023,
                               32'h00000097, 32'h008000ef, 32'h0042d293, 32'h00518463};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_InstSel", int'(InstSel), 1);
        chk("rst_SSel",    int'(SSel),    3);
        chk("rst_RegWrEn", int'(RegWrEn), 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("release_InstSel", int'(InstSel), 1);
        drive(BUB, 0, 0);
        @(negedge clk);
        chk("run_InstSel", int'(InstSel), 0);

        drive(LW, 0, 0);
        drive(SH, 0, 0);
        @(negedge clk);
        chk("lw_BSel", int'(BSel), 1);   chk("lw_ASel", int'(ASel), 0);
        chk("lw_ALUSel", int'(ALUSel), 0); chk("lw_MemRW", int'(MemRW), 1);
        chk("lw_SSel", int'(SSel), 3);
        drive(SUB, 0, 0);
        @(negedge clk);
        chk("sh_SSel", int'(SSel), 1);   chk("sh_MemRW", int'(MemRW), 1);
        chk("lw_WBSel", int'(WBSel), 0); chk("lw_RegWrEn", int'(RegWrEn), 1);
        chk("lw_LdSel", int'(LdSel), 2);
        drive(SRAI, 0, 0);
        @(negedge clk);
        chk("sub_ALUSel", int'(ALUSel), 8); chk("sub_BSel", int'(BSel), 0);
        chk("sh_RegWrEn", int'(RegWrEn), 0);
        drive(LUI, 0, 0);
        @(negedge clk);
        chk("srai_ALUSel", int'(ALUSel), 13); chk("srai_BSel", int'(BSel), 1);
        chk("sub_WBSel", int'(WBSel), 1);     chk("sub_RegWrEn", int'(RegWrEn), 1);
        chk("lui_FB_1", int'(FB_1), 0);       // lui imm bits hold 3 in rs2 field
        drive(BGEU, 0, 0);
        @(negedge clk);
        chk("lui_ALUSel", int'(ALUSel), 15);
        chk("lui_FA_2", int'(FA_2), 0); chk("lui_FB_2", int'(FB_2), 0);
        drive(BGEU, 0, 1);
        @(negedge clk);
        chk("bgeu_lt_PCSel", int'(PCSel), 0); chk("bgeu_BrUn", int'(BrUn), 1);
        drive(BEQ, 0, 0);
        @(negedge clk);
        chk("bgeu_ge_PCSel", int'(PCSel), 1);
        drive(JALR, 1, 0);
        @(negedge clk);
        chk("beq_PCSel", int'(PCSel), 1); chk("beq_BrUn", int'(BrUn), 0);
        drive(ADD1, 0, 0);
        @(negedge clk);
        chk("jalr_ASel", int'(ASel), 0); chk("jalr_BSel", int'(BSel), 1);
        chk("jalr_PCSel", int'(PCSel), 1);
        drive(ADD2, 0, 0);
        @(negedge clk);
        chk("jalr_WBSel", int'(WBSel), 2); chk("jalr_RegWrEn", int'(RegWrEn), 1);
        chk("x0_FA_1", int'(FA_1), 0);
        drive(BUB, 0, 0);
        @(negedge clk);
        chk("add_FA_2", int'(FA_2), int'(FWD_ON));
        chk("add_FB_2", int'(FB_2), int'(FWD_ON));
        drive(ADD1, 0, 0);
        drive(BUB, 0, 0);
        drive(ADD2, 0, 0);
        @(negedge clk);
        chk("add_FA_1", int'(FA_1), int'(FWD_ON));
        chk("add_FB_1", int'(FB_1), int'(FWD_ON));

        // Mixed program with arbitrary comparator flags; the model checks it.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) begin
                drive(prog[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // Reset with instructions in flight.
        drive(ADD1, 0, 0);
        drive(ADD2, 0, 0);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        chk("midrst_InstSel", int'(InstSel), 1);
        chk("midrst_RegWrEn", int'(RegWrEn), 0);
        chk("midrst_MemRW",   int'(MemRW),   0);
        chk("midrst_PCSel",   int'(PCSel),   0);
        inst = BUB;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rerelease_InstSel", int'(InstSel), 1);
        drive(LW, 0, 0);
        @(negedge clk);
        chk("rerun_InstSel", int'(InstSel), 0);
        drive(BUB, 0, 0);
        drive(BUB, 0, 0);
        @(negedge clk);
        chk("rerun_lw_WBSel", int'(WBSel), 0);
        chk("rerun_lw_RegWrEn", int'(RegWrEn), 1);
        drive(BUB, 0, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Control unit for the 3-stage RV32I pipeline: IF/D, EX, MEM/WB.
- Decodes the fetched instruction and pipelines the control bundle through ID/EX and EX/WB registers.
- Resolves branches in EX from the datapath comparator flags (BrEq, BrLt).
- Generates data-forwarding selects for the decode and execute stages.

Parameters:
- None.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- inst  in  32  instruction currently in IF/D (synchronous instruction-memory output)
- BrEq  in  1  comparator equal flag, for the instruction in EX
- BrLt  in  1  comparator less-than flag, for the instruction in EX (signedness selected by BrUn)
- FA_1  out  1  IF/D: bypass WB write data onto the rs1 read
- FB_1  out  1  IF/D: bypass WB write data onto the rs2 read
- FA_2  out  1  EX: ALU/comparator operand A takes the WB-stage result
- FB_2  out  1  EX: operand B takes the WB-stage result
- PCSel  out  1  EX: 1 = next PC is the ALU result, 0 = PC+4
- InstSel  out  1  1 = IF/D instruction is replaced with a NOP
- BrUn  out  1  EX: unsigned compare
- ASel  out  1  EX: 0 = rs1, 1 = PC
- BSel  out  1  EX: 0 = rs2, 1 = immediate
- ALUSel  out  4  EX: ALU operation
- MemRW  out  1  EX: data-memory access enable (loads and stores)
- SSel  out  2  EX: store width; 0 = SB, 1 = SH, 2 = SW, 3 = no write
- WBSel  out  2  WB: write-back source; 0 = memory, 1 = ALU, 2 = PC+4
- RegWrEn  out  1  WB: register-file write enable
- LdSel  out  3  WB: load funct3 for the load extender

Behaviour:
- Decode is keyed on inst[6:2]:
  - LOAD=0, I=4, AUIPC=5, STORE=8, R=12, LUI=13, BRANCH=24, JALR=25, JAL=27.
  - Any other opcode decodes to a bubble.
- ALUSel codes: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SUB=8, SRA=13, PASS_B=15.
- R-type: ALUSel={funct7[5],funct3}; ASel=0, BSel=0, WBSel=1, RegWrEn=1.
- I-type ALU: ALUSel={funct3==5 ? funct7[5] : 0, funct3}; ASel=0, BSel=1, WBSel=1, RegWrEn=1.
- LOAD: ADD; ASel=0, BSel=1, MemRW=1, WBSel=0, RegWrEn=1, LdSel=funct3.
- STORE: ADD; ASel=0, BSel=1, MemRW=1, SSel=funct3[1:0], RegWrEn=0.
- BRANCH: ADD; ASel=1, BSel=1, RegWrEn=0, BrUn=funct3[1].
  - PCSel: beq=BrEq, bne=!BrEq, blt/bltu=BrLt, bge/bgeu=!BrLt.
- JAL: ADD; ASel=1, BSel=1, PCSel=1, WBSel=2, RegWrEn=1.
- JALR: ADD; ASel=0, BSel=1, PCSel=1, WBSel=2, RegWrEn=1.
- LUI: PASS_B; BSel=1, WBSel=1, RegWrEn=1.
- AUIPC: ADD; ASel=1, BSel=1, WBSel=1, RegWrEn=1.
- Defaults for any field not listed for an opcode: 0. Exceptions: SSel=3 for every non-store; LdSel=2 for every non-load.
- Bubble: all controls 0, SSel=3, RegWrEn=0, MemRW=0, PCSel=0.
- Latency:
  - FA_1/FB_1 are combinational on inst and the EX/WB register.
  - EX outputs are valid one cycle after inst is presented. PCSel is combinational on BrEq/BrLt within that cycle.
  - WB outputs are valid two cycles after inst is presented.
- No squashing: the PC mux feeds the synchronous instruction memory directly, so the next fetched instruction is always on the correct path.
- Forwarding:
  - A consumer reads rs1 for R/I/LOAD/STORE/BRANCH/JALR, and rs2 for R/STORE/BRANCH.
  - FA_2/FB_2 = 1 when the EX instruction reads that source, the WB instruction has RegWrEn=1 and rd!=0, and rd equals the source.
  - FA_1/FB_1 apply the same rule to the IF/D instruction against the WB instruction.
  - Immediate bits in the rs fields never trigger forwarding.
- Reset (rst low, asynchronous): ID/EX and EX/WB registers load the bubble; all outputs take bubble values; InstSel=1.
- InstSel is also 1 for the first cycle after rst deasserts (instruction memory output not yet valid), then 0.
- Reset asserted mid-operation discards all in-flight instructions.

Optional Feature:
- CTRL_FORWARD_EN defined: forwarding as specified above.
- CTRL_FORWARD_EN undefined: FA_1, FB_1, FA_2, FB_2 tied to 0 and the comparators removed. Hazards are then software's responsibility.

Decomposition:
- Package ctrl_pkg holds the opcode, ALUSel, WBSel and SSel constants, plus a packed control-bundle struct with the bubble constant.
- Sub-module controller_decode: purely combinational inst-to-bundle decoder, instantiated once at IF/D.
- The top level holds the pipeline registers, branch resolution, forwarding and InstSel.

Test Plan:
- lw x2,0(x3) (0x0001a103) -> EX: BSel=1, ASel=0, ALUSel=0, MemRW=1, SSel=3; WB: WBSel=0, RegWrEn=1, LdSel=2.
- sh x2,0(x3) (0x00219023) -> EX: MemRW=1, SSel=1, ALUSel=0; WB: RegWrEn=0.
- sub (0x401201b3) -> ALUSel=8, BSel=0; srai (0x40425193) -> ALUSel=13, BSel=1; both WB: WBSel=1, RegWrEn=1.
- bgeu (0x060f7463): BrLt=1 -> PCSel=0, BrUn=1; BrLt=0 -> PCSel=1. beq (0x060f0e63): BrEq=1 -> PCSel=1, BrUn=0.
- jalr x0,100(x7) (0x06438067) -> ASel=0, BSel=1, PCSel=1; WB: WBSel=2, RegWrEn=1. lui (0x003e8137) -> ALUSel=15, no forwarding asserted.
- add x3,x4,x1 followed by add x5,x3,x3 -> FA_2=1, FB_2=1 in the second instruction's EX cycle. Reset pulse -> bubble outputs and InstSel=1 for one cycle after release.
